// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding and defaults for the sequencer scheduler
// Contents:
//   state_t         FSM states (IDLE=0, START=1, RUN=2, DONE=3, FAULT=4)
//   DEF_STEP_W      default step counter width (sequencer PC width)
//   DEF_MAX_STEPS   default watchdog limit on continue cycles per run
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_RUN   = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  localparam int DEF_STEP_W    = 8;
  localparam int DEF_MAX_STEPS = 255;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick
// Ports:
//   req  in  N    request vector
//   ptr  in  IW   index with highest priority; priority then ascends with wrap
//   gnt  out N    one-hot grant (all zero when req is zero)
//   idx  out IW   index of the granted bit (0 when req is zero)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N; i++) begin
      // Wrap by subtraction so non-power-of-two N needs no divider.
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/seq_scheduler.sv
// rtl/seq_scheduler.sv - round-robin scheduler sharing one microcode sequencer
// Ports:
//   clk           in   clock
//   reset         in   synchronous active-high reset
//   req           in   N_REQ  level request per requester (sampled in IDLE only)
//   hold          in   N_REQ  pause stepping while the indexed requester is granted
//   clear_fault   in   leave FAULT once the sequencer is ready
//   seq_ready     in   sequencer idle
//   seq_start     out  one-cycle start pulse to the sequencer
//   seq_continue  out  PC advance to the sequencer
//   grant         out  N_REQ  one-hot, START through DONE
//   done          out  N_REQ  one-cycle completion pulse to the winner
//   fault         out  high while in FAULT
//   busy          out  state != IDLE
//   active_id     out  ID_W   current/last winner
//   last_steps    out  STEP_W continue-cycle count of the last completed run
module seq_scheduler
  import seq_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int ID_W      = 2,
  parameter int STEP_W    = DEF_STEP_W,
  parameter int MAX_STEPS = DEF_MAX_STEPS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_REQ-1:0]  req,
  input  logic [N_REQ-1:0]  hold,
  input  logic              clear_fault,
  input  logic              seq_ready,
  output logic              seq_start,
  output logic              seq_continue,
  output logic [N_REQ-1:0]  grant,
  output logic [N_REQ-1:0]  done,
  output logic              fault,
  output logic              busy,
  output logic [ID_W-1:0]   active_id,
  output logic [STEP_W-1:0] last_steps
);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [STEP_W-1:0]   step_cnt;
  logic [STEP_W-1:0]   step_nxt;
  logic                first_run;
  logic [N_REQ-1:0]    arb_gnt;
  logic [ID_W-1:0]     arb_idx;
  logic [ID_W-1:0]     id_inc;

  rr_arbiter #(.N(N_REQ), .IW(ID_W)) u_arb (
    .req (req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Count includes the continue issued in the current cycle; saturates.
  assign step_nxt = (seq_continue && (step_cnt != '1)) ? step_cnt + STEP_W'(1) : step_cnt;
  assign id_inc   = (active_id == ID_W'(N_REQ - 1)) ? '0 : active_id + ID_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      step_cnt     <= '0;
      first_run    <= 1'b0;
      seq_start    <= 1'b0;
      seq_continue <= 1'b0;
      grant        <= '0;
      done         <= '0;
      fault        <= 1'b0;
      busy         <= 1'b0;
      active_id    <= '0;
      last_steps   <= '0;
    end else begin
      seq_start <= 1'b0;
      done      <= '0;
      case (state)
        ST_IDLE: begin
          if (seq_ready && (|req)) begin
            grant     <= arb_gnt;
            active_id <= arb_idx;
            seq_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_START;
          end
        end
        ST_START: begin
          step_cnt     <= '0;
          first_run    <= 1'b1;
          seq_continue <= ~hold[active_id];
          state        <= ST_RUN;
        end
        ST_RUN: begin
          first_run <= 1'b0;
          step_cnt  <= step_nxt;
          // Ready seen in the first RUN cycle may be left over from before
          // the start pulse, so completion is only honoured afterwards.
          // Completion takes priority over the watchdog.
          if (!first_run && seq_ready) begin
            seq_continue      <= 1'b0;
            last_steps        <= step_cnt;
            done[active_id]   <= 1'b1;
            state             <= ST_DONE;
          end else if (step_nxt == STEP_W'(MAX_STEPS)) begin
            seq_continue <= 1'b0;
            grant        <= '0;
            fault        <= 1'b1;
            state        <= ST_FAULT;
          end else begin
            seq_continue <= ~hold[active_id];
          end
        end
        ST_DONE: begin
          grant  <= '0;
          rr_ptr <= id_inc;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        ST_FAULT: begin
          if (clear_fault && seq_ready) begin
            fault <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_scheduler.sv
// tb/tb_seq_scheduler.sv - self-checking bench for seq_scheduler
module tb_seq_scheduler;

  localparam int N    = 4;
  localparam int IW   = 2;
  localparam int SW   = 8;
  localparam int MAXS = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  hold = '0;
  logic          clear_fault = 1'b0;
  logic          seq_ready;
  logic          seq_start;
  logic          seq_continue;
  logic [N-1:0]  grant;
  logic [N-1:0]  done;
  logic          fault;
  logic          busy;
  logic [IW-1:0] active_id;
  logic [SW-1:0] last_steps;

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;
  int exp_last = 0;

  always #5 clk = ~clk;

  seq_scheduler #(.N_REQ(N), .ID_W(IW), .STEP_W(SW), .MAX_STEPS(MAXS)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .hold         (hold),
    .clear_fault  (clear_fault),
    .seq_ready    (seq_ready),
    .seq_start    (seq_start),
    .seq_continue (seq_continue),
    .grant        (grant),
    .done         (done),
    .fault        (fault),
    .busy         (busy),
    .active_id    (active_id),
    .last_steps   (last_steps)
  );

  // Sequencer model: finishes after tgt accepted continues; optional stale
  // ready for one cycle after start; force_idle aborts a runaway program.
  int   tgt = 10;
  int   cnt;
  logic running;
  logic stale;
  logic stale_mode = 1'b0;
  logic force_idle = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      running <= 1'b0;
      stale   <= 1'b0;
      cnt     <= 0;
    end else if (seq_start) begin
      running <= 1'b1;
      stale   <= stale_mode;
      cnt     <= 0;
    end else begin
      stale <= 1'b0;
      if (force_idle) running <= 1'b0;
      else if (running && seq_continue) begin
        cnt <= cnt + 1;
        if (cnt + 1 == tgt) running <= 1'b0;
      end
    end
  end

  assign seq_ready = !running || stale;

  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (r[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] bit_of(input int i);
    logic [N-1:0] one;
    one = 1;
    return one << i;
  endfunction

  // Drives one run from IDLE to done or fault and reports what it saw.
  task automatic do_run(input int hs, input int hl,
                        output int winner, output int n_start, output int n_cont,
                        output int latency, output logic [N-1:0] done_seen,
                        output logic faulted, output logic timed_out);
    int   start_c;
    logic started;
    winner = -1; n_start = 0; n_cont = 0; latency = -1; done_seen = '0;
    faulted = 1'b0; timed_out = 1'b1; started = 1'b0; start_c = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (seq_start) begin
        n_start++;
        if (!started) begin
          started = 1'b1;
          start_c = c;
          winner  = onehot_idx(grant);
        end
      end
      if (seq_continue && running) n_cont++;
      if (done != '0) begin
        done_seen = done; latency = c - start_c; timed_out = 1'b0;
        break;
      end
      if (fault) begin
        faulted = 1'b1; timed_out = 1'b0;
        break;
      end
      if (started && winner >= 0) begin
        if (c - start_c >= hs && c - start_c < hs + hl) hold = N'($urandom) | bit_of(winner);
        else hold = N'($urandom) & ~bit_of(winner);
      end else begin
        hold = '0;
      end
    end
    hold = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({seq_start, seq_continue, fault, busy} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000", {seq_start, seq_continue, fault, busy});
    end
    checks++;
    if ({grant, done} !== '0) begin
      errors++; $display("FAIL reset_vec got grant=%b done=%b want 0", grant, done);
    end
    checks++;
    if (active_id !== '0 || last_steps !== '0) begin
      errors++; $display("FAIL reset_id got id=%0d steps=%0d want 0 0", active_id, last_steps);
    end
    reset = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_single;
    int w, ns, nc, lat; logic [N-1:0] dn; logic flt, to;
    req = 4'b0001; tgt = 10;
    do_run(1000, 0, w, ns, nc, lat, dn, flt, to);
    req = '0;
    checks++;
    if (to || flt || w != 0 || ns != 1 || nc != 10) begin
      errors++; $display("FAIL single_run got to=%0b flt=%0b w=%0d starts=%0d cont=%0d want 0 0 0 1 10", to, flt, w, ns, nc);
    end
    checks++;
    if (dn !== 4'b0001 || last_steps !== SW'(10) || lat != 12) begin
      errors++; $display("FAIL single_done got done=%b steps=%0d lat=%0d want 0001 10 12", dn, last_steps, lat);
    end
    @(negedge clk);
    checks++;
    if (grant !== '0 || done !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_after got grant=%b done=%b busy=%b want 0 0 0", grant, done, busy);
    end
    exp_ptr = 1; exp_last = 10;
  endtask

  task automatic test_rr;
    int w, ns, nc, lat, e; logic [N-1:0] dn; logic flt, to;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tgt = $urandom_range(12, 3);
      e = rr_pick(req, exp_ptr);
      do_run(1000, 0, w, ns, nc, lat, dn, flt, to);
      checks++;
      if (to || w != e || dn !== bit_of(e) || last_steps !== SW'(tgt) || lat != tgt + 2) begin
        errors++; $display("FAIL rr_run%0d got w=%0d done=%b steps=%0d lat=%0d want w=%0d steps=%0d lat=%0d", k, w, dn, last_steps, lat, e, tgt, tgt + 2);
      end
      exp_ptr = (e + 1) % N; exp_last = tgt;
    end
    req = '0;
  endtask

  task automatic test_hold;
    int w, ns, nc, lat, e; logic [N-1:0] dn; logic flt, to;
    req = 4'b0100; tgt = 10;
    e = rr_pick(req, exp_ptr);
    do_run(3, 5, w, ns, nc, lat, dn, flt, to);
    req = '0;
    checks++;
    if (to || w != e || dn !== bit_of(e) || last_steps !== SW'(10) || nc != 10 || lat != 17) begin
      errors++; $display("FAIL hold_run got w=%0d done=%b steps=%0d cont=%0d lat=%0d want w=%0d 10 10 17", w, dn, last_steps, nc, lat, e);
    end
    exp_ptr = (e + 1) % N; exp_last = 10;
  endtask

  task automatic test_stale_ready;
    int w, ns, nc, lat, e; logic [N-1:0] dn; logic flt, to;
    req = 4'b0001; tgt = 6; stale_mode = 1'b1;
    e = rr_pick(req, exp_ptr);
    do_run(1000, 0, w, ns, nc, lat, dn, flt, to);
    req = '0; stale_mode = 1'b0;
    checks++;
    if (to || w != e || dn !== bit_of(e) || last_steps !== SW'(6) || lat != 8) begin
      errors++; $display("FAIL stale_ready got w=%0d done=%b steps=%0d lat=%0d want w=%0d 6 8", w, dn, last_steps, lat, e);
    end
    exp_ptr = (e + 1) % N; exp_last = 6;
  endtask

  task automatic test_random;
    int w, ns, nc, lat, e, hs, hl; logic [N-1:0] dn; logic flt, to;
    for (int k = 0; k < 12; k++) begin
      req = N'($urandom_range(15, 1));
      tgt = $urandom_range(30, 2);
      hl  = $urandom_range(6, 0);
      hs  = $urandom_range(tgt - 1, 1);
      stale_mode = 1'($urandom);
      e = rr_pick(req, exp_ptr);
      do_run(hs, hl, w, ns, nc, lat, dn, flt, to);
      checks++;
      if (to || flt || w != e || dn !== bit_of(e) || last_steps !== SW'(tgt) || lat != tgt + 2 + hl) begin
        errors++; $display("FAIL random_run%0d got w=%0d done=%b steps=%0d lat=%0d want w=%0d steps=%0d lat=%0d", k, w, dn, last_steps, lat, e, tgt, tgt + 2 + hl);
      end
      exp_ptr = (e + 1) % N; exp_last = tgt;
    end
    req = '0; stale_mode = 1'b0;
  endtask

  task automatic test_watchdog;
    int w, ns, nc, lat, e; logic [N-1:0] dn; logic flt, to;
    req = 4'b0010; tgt = 100000;
    e = rr_pick(req, exp_ptr);
    do_run(1000, 0, w, ns, nc, lat, dn, flt, to);
    req = '0;
    checks++;
    if (!flt || w != e || nc != MAXS || dn !== '0) begin
      errors++; $display("FAIL wdog_trip got flt=%0b w=%0d cont=%0d done=%b want 1 %0d %0d 0", flt, w, nc, dn, e, MAXS);
    end
    checks++;
    if (fault !== 1'b1 || grant !== '0 || seq_continue !== 1'b0 || last_steps !== SW'(exp_last)) begin
      errors++; $display("FAIL wdog_state got fault=%b grant=%b cont=%b steps=%0d want 1 0 0 %0d", fault, grant, seq_continue, last_steps, exp_last);
    end
    clear_fault = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (fault !== 1'b1 || busy !== 1'b1 || done !== '0) begin
      errors++; $display("FAIL wdog_clear_notready got fault=%b busy=%b done=%b want 1 1 0", fault, busy, done);
    end
    force_idle = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (fault !== 1'b0 || busy !== 1'b0 || grant !== '0) begin
      errors++; $display("FAIL wdog_clear_ready got fault=%b busy=%b grant=%b want 0 0 0", fault, busy, grant);
    end
    clear_fault = 1'b0; force_idle = 1'b0;
  endtask

  task automatic test_reset_mid;
    int w, ns, nc, lat, e; logic [N-1:0] dn; logic flt, to; logic seen;
    req = 4'b0010; tgt = 5;
    e = rr_pick(req, exp_ptr);
    do_run(1000, 0, w, ns, nc, lat, dn, flt, to);
    exp_ptr = (e + 1) % N;
    req = 4'b1010; tgt = 50;
    e = rr_pick(req, exp_ptr);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (seq_start) begin seen = 1'b1; break; end
    end
    checks++;
    if (!seen || onehot_idx(grant) != e) begin
      errors++; $display("FAIL rst_mid_grant got seen=%0b grant=%b want 1 idx %0d", seen, grant, e);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({seq_start, seq_continue, fault, busy} !== 4'b0 || grant !== '0 || done !== '0 ||
        active_id !== '0 || last_steps !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got ctl=%b grant=%b done=%b id=%0d steps=%0d want all 0",
                         {seq_start, seq_continue, fault, busy}, grant, done, active_id, last_steps);
    end
    reset = 1'b0; exp_ptr = 0; tgt = 7;
    e = rr_pick(req, exp_ptr);
    do_run(1000, 0, w, ns, nc, lat, dn, flt, to);
    req = '0;
    checks++;
    if (to || w != e || dn !== bit_of(e) || last_steps !== SW'(7)) begin
      errors++; $display("FAIL rst_mid_regrant got w=%0d done=%b steps=%0d want w=%0d steps=7", w, dn, last_steps, e);
    end
    exp_ptr = (e + 1) % N; exp_last = 7;
  endtask

  initial begin
    test_reset;
    test_single;
    test_rr;
    test_hold;
    test_stale_ready;
    test_random;
    test_watchdog;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
